fifo_rd_stream: RTL and testbench
=================================

// Module: fifo_rd_stream
// PURPOSE
//  Downstream read-side stage for the sync FIFO. Drives the FIFO read strobe,
//  captures the registered FIFO data_out and presents it on a valid/ready stream.
//  Absorbs the FIFO's one-cycle read latency and rule "read ignored when write
//  high" so the consumer sees full throughput with backpressure.
// PARAMETERS
//  WIDTH      32  data width, equal to FIFO WIDTH
//  BUF_DEPTH   4  internal buffer entries; power of two, >= 2
// PORTS
//  clk          in   1          clock
//  reset        in   1          asynchronous, active-high reset
//  clear        in   1          sync flush; same net as FIFO clear
//  fifo_empty   in   1          FIFO empty flag
//  fifo_write   in   1          FIFO write strobe (monitored, not driven)
//  fifo_data    in   WIDTH      FIFO data_out
//  fifo_rd      out  1          FIFO read strobe
//  m_valid      out  1          stream data valid
//  m_ready      in   1          stream consumer ready
//  m_data       out  WIDTH      stream data
//  buf_cnt      out  clog2(BUF_DEPTH)+1  buffer occupancy
//  beat_cnt     out  32         beats delivered (m_valid&&m_ready), wraps
// BEHAVIOUR
//  - Reset/clear: fifo_rd=0, m_valid=0, m_data=0, buf_cnt=0, beat_cnt=0,
//    pending=0, pointers=0. Clear wins over every other event that cycle.
//  - rd_acc = fifo_rd && !fifo_write && !fifo_empty (FIFO acceptance rule).
//  - fifo_rd (comb) = !fifo_empty && !fifo_write && !clear
//    && (buf_cnt + pending) < BUF_DEPTH. No path from m_ready to fifo_rd.
//  - pending: registered rd_acc. When pending=1, fifo_data is valid this cycle
//    and is pushed into the buffer at the next edge.
//  - Latency: rd_acc in cycle T -> m_valid at T+2 if buffer empty. Steady
//    state with m_ready=1 and no fifo_write: one beat per cycle.
//  - Buffer: circular, wr/rd pointers clog2(BUF_DEPTH) bits, natural wrap.
//    Push and pop in same cycle: buf_cnt unchanged. Overflow impossible by
//    credit rule; assertion required.
//  - m_valid = (buf_cnt != 0); m_data = head entry, registered. m_data and
//    m_valid stable while m_valid && !m_ready.
//  - fifo_write high blocks reads; adapter drains buffer meanwhile.
//  - Clear with pending=1: in-flight beat discarded, not pushed.
//  - Reset mid-transfer: all state dropped immediately (async).
// STRUCTURE
//  - fifo_pkg: clog2-based width localparams, stream beat typedef
//    (logic [WIDTH-1:0]), shared with the FIFO bench.
//  - One sub-module: stream_buf (circular buffer + occupancy, push/pop/flush),
//    instantiated once. Credit logic and pending flag live in top level.
// TESTING
//  1 Reset: reset=1 mid-burst -> fifo_rd=0, m_valid=0, buf_cnt=0, beat_cnt=0
//    in the same cycle.
//  2 Stream: FIFO holds 0x10..0x17, m_ready=1 -> m_data 0x10..0x17 on 8
//    consecutive cycles, first beat 2 cycles after first rd_acc, beat_cnt=8.
//  3 Backpressure: m_ready=0 with 8 entries in FIFO -> buf_cnt reaches 4,
//    fifo_rd deasserts, FIFO cnt=4; m_ready=1 -> remaining data in order.
//  4 Write collision: fifo_write=1 every cycle for 5 cycles -> no rd_acc, no
//    beats lost or duplicated; order preserved after fifo_write drops.
//  5 Clear: clear pulse while pending=1 and buf_cnt=3 -> next cycle
//    m_valid=0, buf_cnt=0; next FIFO data 0xAA is the first beat out.
//  6 Wrap: 20 beats with random m_ready -> pointers wrap, scoreboard exact
//    match, m_data stable under stall.

Source files
------------

// File: rtl/fifo_rd_stream_pkg.sv
// fifo_rd_stream_pkg: shared widths, beat type and occupancy-width helper for the FIFO read stage
package fifo_rd_stream_pkg;
    localparam int DEF_WIDTH     = 32;
    localparam int DEF_BUF_DEPTH = 4;
    typedef logic [DEF_WIDTH-1:0] beat_t;
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: valid/ready stream carrying one data beat per handshake
interface fifo_rd_stream_if #(parameter int WIDTH = 32);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fifo_rd_stream_buf.sv
// fifo_rd_stream_buf: circular skid buffer with occupancy count, push/pop/flush
module fifo_rd_stream_buf
    import fifo_rd_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_BUF_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_flush,
    input  logic                      i_push,
    input  logic                      i_pop,
    input  logic [WIDTH-1:0]          i_data,
    output logic [WIDTH-1:0]          o_data,
    output logic [cnt_w(DEPTH)-1:0]   o_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_mem [DEPTH];

    // pointers wrap naturally; simultaneous push and pop leave the count unchanged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + AW'(1);
            if (i_pop) r_rd <= r_rd + AW'(1);
            r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
        end
    end

    // storage needs no reset: the head is only exposed while the count is nonzero
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr] <= i_data;
    end

    assign o_cnt  = r_cnt;
    assign o_data = (r_cnt != '0) ? r_mem[r_rd] : '0;

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(i_push && !i_pop && !i_flush && r_cnt == CW'(DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(i_pop && !i_flush && r_cnt == '0));
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drives the FIFO read strobe and re-presents its data as a valid/ready stream
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int BUF_DEPTH = DEF_BUF_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_clear,
    input  logic                          i_fifo_empty,
    input  logic                          i_fifo_write,
    input  logic [WIDTH-1:0]              i_fifo_data,
    output logic                          o_fifo_rd,
    fifo_rd_stream_if.master              m_if,
    output logic [cnt_w(BUF_DEPTH)-1:0]   o_buf_cnt,
    output logic [31:0]                   o_beat_cnt
);
    localparam int CW = cnt_w(BUF_DEPTH);
    localparam logic [CW:0] LIM = (CW+1)'(BUF_DEPTH);

    logic             r_pending;
    logic [31:0]      r_beat_cnt;
    logic             w_rd_acc;
    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_buf_cnt;
    logic [WIDTH-1:0] w_head;

    // credit check counts the in-flight beat so the buffer can never overflow; m_ready is not involved
    always_comb begin
        o_fifo_rd = !reset && !i_fifo_empty && !i_fifo_write && !i_clear
                    && (({1'b0, w_buf_cnt} + {{CW{1'b0}}, r_pending}) < LIM);
        w_rd_acc  = o_fifo_rd && !i_fifo_write && !i_fifo_empty;
        w_push    = r_pending && !i_clear;
        w_pop     = m_if.valid && m_if.ready && !i_clear;
    end

    // pending marks the cycle in which the FIFO's registered data_out holds the accepted word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending  <= 1'b0;
            r_beat_cnt <= '0;
        end else if (i_clear) begin
            r_pending  <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            r_pending <= w_rd_acc;
            if (w_pop) r_beat_cnt <= r_beat_cnt + 32'd1;
        end
    end

    fifo_rd_stream_buf #(.WIDTH(WIDTH), .DEPTH(BUF_DEPTH)) u_buf (
        .clk    (clk),
        .reset  (reset),
        .i_flush(i_clear),
        .i_push (w_push),
        .i_pop  (w_pop),
        .i_data (i_fifo_data),
        .o_data (w_head),
        .o_cnt  (w_buf_cnt)
    );

    assign m_if.valid = (w_buf_cnt != '0);
    assign m_if.data  = w_head;
    assign o_buf_cnt  = w_buf_cnt;
    assign o_beat_cnt = r_beat_cnt;
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: scoreboard bench with a behavioural sync FIFO feeding the read stage
module tb_fifo_rd_stream;
    import fifo_rd_stream_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        fifo_write = 1'b0;
    logic        fifo_rd;
    logic        fifo_empty;
    beat_t       wdata = '0;
    beat_t       fifo_data = '0;
    logic [2:0]  buf_cnt;
    logic [31:0] beat_cnt;

    fifo_rd_stream_if #(.WIDTH(32)) s_if();

    always #5 clk = ~clk;

    fifo_rd_stream #(.WIDTH(32), .BUF_DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (clear),
        .i_fifo_empty(fifo_empty),
        .i_fifo_write(fifo_write),
        .i_fifo_data (fifo_data),
        .o_fifo_rd   (fifo_rd),
        .m_if        (s_if),
        .o_buf_cnt   (buf_cnt),
        .o_beat_cnt  (beat_cnt)
    );

    // behavioural sync FIFO: registered data_out, read ignored while write is high
    beat_t      fmem [64];
    logic [5:0] fwp = '0;
    logic [5:0] frp = '0;
    int         fcnt = 0;
    assign fifo_empty = (fcnt == 0);

    always @(posedge clk) begin
        if (clear) begin
            fwp  <= '0;
            frp  <= '0;
            fcnt <= 0;
        end else begin
            if (fifo_write) begin
                fmem[fwp] <= wdata;
                fwp <= fwp + 6'd1;
            end
            if (fifo_rd && !fifo_write && fcnt != 0) begin
                fifo_data <= fmem[frp];
                frp <= frp + 6'd1;
            end
            fcnt <= fcnt + (fifo_write ? 1 : 0) - ((fifo_rd && !fifo_write && fcnt != 0) ? 1 : 0);
        end
    end

    // scoreboard monitor: every handshake pops the oldest expected word; stalls must hold data
    beat_t exp_q[$];
    beat_t mon_e;
    beat_t stall_d = '0;
    logic  stall = 1'b0;
    int    n_vec = 0;
    int    n_err = 0;

    always @(negedge clk) begin
        if (!reset && !clear) begin
            if (stall) begin
                n_vec++;
                if (s_if.valid !== 1'b1 || s_if.data !== stall_d) begin
                    n_err++;
                    $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h", s_if.valid, s_if.data, stall_d);
                end
            end
            if (s_if.valid && s_if.ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL beat_extra: data=%h, required no beat", s_if.data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (s_if.data !== mon_e) begin
                        n_err++;
                        $display("FAIL beat_data: data=%h, required %h", s_if.data, mon_e);
                    end
                end
            end
            stall = s_if.valid && !s_if.ready;
            stall_d = s_if.data;
        end else begin
            stall = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input beat_t v);
        wdata = v;
        fifo_write = 1'b1;
        exp_q.push_back(v);
        step();
        fifo_write = 1'b0;
    endtask

    task automatic drain(input int bound);
        int k = 0;
        while ((exp_q.size() != 0 || s_if.valid) && k < bound) begin
            step();
            k++;
        end
        n_vec++;
        if (exp_q.size() != 0 || s_if.valid) begin
            n_err++;
            $display("FAIL drain_timeout: %0d beats outstanding after %0d cycles, required 0", exp_q.size(), bound);
        end
    endtask

    task automatic test_reset();
        s_if.ready = 1'b0;
        step();
        step();
        n_vec++;
        if (fifo_rd !== 1'b0 || s_if.valid !== 1'b0 || s_if.data !== '0 || buf_cnt !== 3'd0 || beat_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL reset_init: rd=%b valid=%b data=%h cnt=%0d beats=%0d, required all 0", fifo_rd, s_if.valid, s_if.data, buf_cnt, beat_cnt);
        end
        reset = 1'b0;
        s_if.ready = 1'b1;
        for (int i = 1; i <= 6; i++) push(beat_t'(i));
        step();
        step();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        n_vec++;
        if (fifo_rd !== 1'b0 || s_if.valid !== 1'b0 || buf_cnt !== 3'd0 || beat_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL reset_midburst: rd=%b valid=%b cnt=%0d beats=%0d, required all 0", fifo_rd, s_if.valid, buf_cnt, beat_cnt);
        end
        step();
        step();
        reset = 1'b0;
        clear = 1'b1;
        exp_q.delete();
        step();
        clear = 1'b0;
    endtask

    task automatic test_stream();
        s_if.ready = 1'b1;
        for (int i = 0; i < 8; i++) push(beat_t'(32'h10 + i));
        #1;
        n_vec++;
        if (fifo_rd !== 1'b1) begin
            n_err++;
            $display("FAIL stream_rd: rd=%b, required 1", fifo_rd);
        end
        step();
        #1;
        n_vec++;
        if (s_if.valid !== 1'b0) begin
            n_err++;
            $display("FAIL stream_latency: valid=%b one cycle after rd_acc, required 0", s_if.valid);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            #1;
            n_vec++;
            if (s_if.valid !== 1'b1 || s_if.data !== beat_t'(32'h10 + i)) begin
                n_err++;
                $display("FAIL stream_beat%0d: valid=%b data=%h, required valid=1 data=%h", i, s_if.valid, s_if.data, 32'h10 + i);
            end
        end
        step();
        #1;
        n_vec++;
        if (s_if.valid !== 1'b0 || beat_cnt !== 32'd8) begin
            n_err++;
            $display("FAIL stream_end: valid=%b beats=%0d, required valid=0 beats=8", s_if.valid, beat_cnt);
        end
    endtask

    task automatic test_backpressure();
        s_if.ready = 1'b0;
        for (int i = 0; i < 8; i++) push(beat_t'(32'h20 + i));
        repeat (8) step();
        #1;
        n_vec++;
        if (buf_cnt !== 3'd4 || fifo_rd !== 1'b0 || fcnt != 4) begin
            n_err++;
            $display("FAIL bp_full: cnt=%0d rd=%b fifo_cnt=%0d, required cnt=4 rd=0 fifo_cnt=4", buf_cnt, fifo_rd, fcnt);
        end
        n_vec++;
        if (s_if.valid !== 1'b1 || s_if.data !== 32'h20) begin
            n_err++;
            $display("FAIL bp_head: valid=%b data=%h, required valid=1 data=20", s_if.valid, s_if.data);
        end
        s_if.ready = 1'b1;
        drain(40);
        n_vec++;
        if (beat_cnt !== 32'd16) begin
            n_err++;
            $display("FAIL bp_beats: beats=%0d, required 16", beat_cnt);
        end
    endtask

    task automatic test_write_collision();
        s_if.ready = 1'b1;
        for (int i = 0; i < 8; i++) push(beat_t'(32'h30 + i));
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            wdata = beat_t'(32'h38 + i);
            fifo_write = 1'b1;
            exp_q.push_back(wdata);
            #1;
            n_vec++;
            if (fifo_rd !== 1'b0) begin
                n_err++;
                $display("FAIL coll_rd%0d: rd=%b while write high, required 0", i, fifo_rd);
            end
            step();
        end
        fifo_write = 1'b0;
        drain(60);
        n_vec++;
        if (beat_cnt !== 32'd29) begin
            n_err++;
            $display("FAIL coll_beats: beats=%0d, required 29", beat_cnt);
        end
    endtask

    task automatic test_clear();
        int k = 0;
        s_if.ready = 1'b0;
        for (int i = 0; i < 6; i++) push(beat_t'(32'h40 + i));
        while (buf_cnt != 3'd3 && k < 10) begin
            step();
            k++;
        end
        n_vec++;
        if (buf_cnt !== 3'd3) begin
            n_err++;
            $display("FAIL clr_setup: cnt=%0d, required 3", buf_cnt);
        end
        clear = 1'b1;
        exp_q.delete();
        step();
        clear = 1'b0;
        #1;
        n_vec++;
        if (s_if.valid !== 1'b0 || buf_cnt !== 3'd0 || s_if.data !== '0 || beat_cnt !== 32'd0 || fcnt != 0) begin
            n_err++;
            $display("FAIL clr_state: valid=%b cnt=%0d data=%h beats=%0d fifo_cnt=%0d, required all 0", s_if.valid, buf_cnt, s_if.data, beat_cnt, fcnt);
        end
        push(32'hAA);
        k = 0;
        while (!s_if.valid && k < 10) begin
            step();
            k++;
        end
        n_vec++;
        if (s_if.valid !== 1'b1 || s_if.data !== 32'hAA) begin
            n_err++;
            $display("FAIL clr_first: valid=%b data=%h, required valid=1 data=aa", s_if.valid, s_if.data);
        end
        s_if.ready = 1'b1;
        drain(20);
    endtask

    task automatic test_wrap();
        int k = 0;
        for (int i = 0; i < 20; i++) begin
            s_if.ready = 1'($urandom_range(0, 1));
            push(beat_t'($urandom));
        end
        while ((exp_q.size() != 0 || s_if.valid) && k < 400) begin
            s_if.ready = 1'($urandom_range(0, 1));
            step();
            k++;
        end
        s_if.ready = 1'b1;
        drain(20);
        n_vec++;
        if (beat_cnt !== 32'd21) begin
            n_err++;
            $display("FAIL wrap_beats: beats=%0d, required 21", beat_cnt);
        end
    endtask

    initial begin
        s_if.ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_write_collision();
        test_clear();
        test_wrap();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule
